// File: rtl/calc_pkg.sv
// ============================================================================
// Module  : calc_pkg
// Purpose : Shared definitions for the calculator sequencer: FSM state
//           encoding, display-source codes, default op count and small
//           helpers mapping a state to its registered output values.
// Ports   : none (package)
// Options : CALC_TIMEOUT_EN (used by calc_seq_ctrl; ERROR state only
//           reachable when defined)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OP_SEL     = 3'd1,
    CONV_START = 3'd2,
    CONV_WAIT  = 3'd3,
    RESULT     = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [1:0] DISP_ZEROS = 2'd0;
  localparam logic [1:0] DISP_OP    = 2'd1;
  localparam logic [1:0] DISP_RES   = 2'd2;
  localparam logic [1:0] DISP_ERR   = 2'd3;

  localparam int DEFAULT_NUM_OPS = 8;

  // Display source shown while sitting in a given state.
  function automatic logic [1:0] disp_for(state_t s);
    case (s)
      OP_SEL, CONV_START, CONV_WAIT: disp_for = DISP_OP;
      RESULT:                        disp_for = DISP_RES;
      ERROR:                         disp_for = DISP_ERR;
      default:                       disp_for = DISP_ZEROS;
    endcase
  endfunction

  // Busy covers the whole conversion handshake.
  function automatic logic busy_for(state_t s);
    busy_for = (s == CONV_START) || (s == CONV_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_btn_edge.sv
// ============================================================================
// Module  : calc_btn_edge
// Purpose : Turns a debounced button level into a one-cycle press pulse.
//           The previous-level register is preloaded with the live level
//           during reset, so a button held through reset release never
//           produces a press.
// Ports   : clk   in  system clock
//           rst   in  synchronous active-low reset
//           lvl   in  debounced button level
//           press out combinational rising-edge pulse (lvl & ~prev)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic press
);

  logic prev;

  // prev tracks lvl both in and out of reset; the reset branch is kept
  // explicit because the preload is what suppresses a held-through press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= lvl;
    end else begin
      prev <= lvl;
    end
  end

  assign press = lvl & ~prev;

endmodule

`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
// ============================================================================
// Module  : calc_seq_ctrl
// Purpose : Calculator sequencer. Converts button levels into single-press
//           actions, steps op selection, runs the BCD converter start/rdy
//           handshake, latches the result and selects the display source.
// Ports   : clk        in  system clock
//           rst        in  synchronous active-low reset
//           up_lvl     in  debounced up level
//           down_lvl   in  debounced down level
//           enter_lvl  in  debounced enter level
//           back_lvl   in  debounced back level
//           conv_rdy   in  converter done, conv_bcd valid while high
//           conv_bcd   in  converter result [BCD_W]
//           op         out selected op [OP_W]
//           conv_start out one-cycle conversion request
//           result_bcd out latched result [BCD_W]
//           disp_sel   out 0 zeros, 1 op text, 2 result, 3 error
//           busy       out high in CONV_START and CONV_WAIT
// Options : CALC_TIMEOUT_EN - abort CONV_WAIT into ERROR after
//           TIMEOUT_CYCLES cycles without conv_rdy.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_OPS        = DEFAULT_NUM_OPS,
  parameter int OP_W           = 3,
  parameter int BCD_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_lvl,
  input  logic             down_lvl,
  input  logic             enter_lvl,
  input  logic             back_lvl,
  input  logic             conv_rdy,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic [OP_W-1:0]  op,
  output logic             conv_start,
  output logic [BCD_W-1:0] result_bcd,
  output logic [1:0]       disp_sel,
  output logic             busy
);

  localparam logic [OP_W-1:0] OP_MAX = OP_W'(NUM_OPS - 1);

  state_t state;

  logic up_p;
  logic down_p;
  logic enter_p;
  logic back_p;

  calc_btn_edge u_edge_up    (.clk(clk), .rst(rst), .lvl(up_lvl),    .press(up_p));
  calc_btn_edge u_edge_down  (.clk(clk), .rst(rst), .lvl(down_lvl),  .press(down_p));
  calc_btn_edge u_edge_enter (.clk(clk), .rst(rst), .lvl(enter_lvl), .press(enter_p));
  calc_btn_edge u_edge_back  (.clk(clk), .rst(rst), .lvl(back_lvl),  .press(back_p));

  // Wrapping op neighbours; a simultaneous up+down press cancels out.
  logic [OP_W-1:0] op_inc;
  logic [OP_W-1:0] op_dec;
  logic            step_up;
  logic            step_down;

  assign op_inc    = (op == OP_MAX) ? '0 : op + OP_W'(1);
  assign op_dec    = (op == '0) ? OP_MAX : op - OP_W'(1);
  assign step_up   = up_p & ~down_p;
  assign step_down = down_p & ~up_p;

`ifdef CALC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Outputs are written together with every state change so they always
  // describe the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= '0;
      result_bcd <= '0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      disp_sel   <= DISP_ZEROS;
`ifdef CALC_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      conv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (up_p | down_p) begin
            state    <= OP_SEL;
            op       <= '0;
            disp_sel <= disp_for(OP_SEL);
            busy     <= busy_for(OP_SEL);
          end else if (enter_p) begin
            state      <= CONV_START;
            conv_start <= 1'b1;
            disp_sel   <= disp_for(CONV_START);
            busy       <= busy_for(CONV_START);
          end
        end

        OP_SEL: begin
          if (enter_p) begin
            state      <= CONV_START;
            conv_start <= 1'b1;
            disp_sel   <= disp_for(CONV_START);
            busy       <= busy_for(CONV_START);
          end else if (back_p) begin
            state    <= IDLE;
            op       <= '0;
            disp_sel <= disp_for(IDLE);
            busy     <= busy_for(IDLE);
          end else if (step_up) begin
            op <= op_inc;
          end else if (step_down) begin
            op <= op_dec;
          end
        end

        // conv_rdy is deliberately not looked at here.
        CONV_START: begin
          state    <= CONV_WAIT;
          disp_sel <= disp_for(CONV_WAIT);
          busy     <= busy_for(CONV_WAIT);
`ifdef CALC_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end

        CONV_WAIT: begin
          if (conv_rdy) begin
            state      <= RESULT;
            result_bcd <= conv_bcd;
            disp_sel   <= disp_for(RESULT);
            busy       <= busy_for(RESULT);
`ifdef CALC_TIMEOUT_EN
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state    <= ERROR;
            disp_sel <= disp_for(ERROR);
            busy     <= busy_for(ERROR);
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end

        RESULT: begin
          if (enter_p) begin
            state      <= CONV_START;
            conv_start <= 1'b1;
            disp_sel   <= disp_for(CONV_START);
            busy       <= busy_for(CONV_START);
          end else if (up_p | down_p) begin
            state    <= OP_SEL;
            disp_sel <= disp_for(OP_SEL);
            busy     <= busy_for(OP_SEL);
          end else if (back_p) begin
            state      <= IDLE;
            op         <= '0;
            result_bcd <= '0;
            disp_sel   <= disp_for(IDLE);
            busy       <= busy_for(IDLE);
          end
        end

`ifdef CALC_TIMEOUT_EN
        ERROR: begin
          if (enter_p) begin
            state      <= CONV_START;
            conv_start <= 1'b1;
            disp_sel   <= disp_for(CONV_START);
            busy       <= busy_for(CONV_START);
          end else if (back_p) begin
            state    <= IDLE;
            op       <= '0;
            disp_sel <= disp_for(IDLE);
            busy     <= busy_for(IDLE);
          end
        end
`endif

        default: begin
          state      <= IDLE;
          op         <= '0;
          conv_start <= 1'b0;
          disp_sel   <= DISP_ZEROS;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Sequencer for the calculator datapath. It turns debounced button levels into single-press actions and steps through op selection. It starts a BCD conversion with a start/rdy handshake, latches the converted result, and tells the display mux what to show. It sits between the Debounce instances and the calculator, BCD converter and display driver, replacing ad-hoc per-button edge logic and the next-state handling.

Parameters:
NUM_OPS, 8, number of selectable ops; op wraps modulo NUM_OPS.
OP_W, 3, op width; must satisfy 2**OP_W >= NUM_OPS.
BCD_W, 16, width of BCD result bus.
TIMEOUT_CYCLES, 1024, CONV_WAIT cycle limit (used only with CALC_TIMEOUT_EN).

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous, active-low reset.
up_lvl  in  1  debounced up button level.
down_lvl  in  1  debounced down button level.
enter_lvl  in  1  debounced enter button level.
back_lvl  in  1  debounced back button level.
conv_rdy  in  1  converter done; conv_bcd valid while high.
conv_bcd  in  BCD_W  converter output.
op  out  OP_W  selected op, to the calculator.
conv_start  out  1  one-cycle conversion request.
result_bcd  out  BCD_W  latched result.
disp_sel  out  2  display source: 0 zeros, 1 op text, 2 result, 3 error.
busy  out  1  high in CONV_START and CONV_WAIT.

Behaviour:
- Reset (rst==0 at a posedge):
  - State IDLE; op=0, result_bcd=0, conv_start=0, busy=0, disp_sel=0.
  - Each prev-level register loads the current level, so a button held through reset release produces no action.
- Edge detection: press = lvl & ~prev, with prev <= lvl every cycle. The FSM acts on the press at the same posedge. A held button yields exactly one action.
- All outputs are registered; output values reflect the current state.
- IDLE (disp_sel 0):
  - up or down press -> OP_SEL, op=0.
  - Else enter press -> CONV_START.
- OP_SEL (disp_sel 1):
  - up press: op=(op+1) mod NUM_OPS.
  - down press: op=op-1, wrapping 0 -> NUM_OPS-1.
  - up and down pressed in the same cycle: op unchanged.
  - enter press -> CONV_START. back press -> IDLE with op=0. If enter and back are pressed together, enter wins.
- CONV_START (disp_sel 1, busy 1):
  - conv_start=1 for exactly this one cycle; next state CONV_WAIT.
  - conv_rdy is ignored in this state.
- CONV_WAIT (disp_sel 1, busy 1):
  - On conv_rdy=1: result_bcd<=conv_bcd, then -> RESULT.
  - All button presses are ignored; op is frozen.
- RESULT (disp_sel 2):
  - up or down press -> OP_SEL, keeping the current op (the press does not step op).
  - enter press -> CONV_START (recompute).
  - back press -> IDLE, op=0, result_bcd=0.
  - Priority: enter > up/down > back.
- conv_rdy outside CONV_WAIT is ignored.
- Reset mid-conversion aborts immediately. A late conv_rdy is ignored.
- Unused state encodings return to IDLE.

Optional Feature:
CALC_TIMEOUT_EN
- Defined:
  - A counter clears on entry to CONV_WAIT.
  - After TIMEOUT_CYCLES cycles in CONV_WAIT without conv_rdy -> ERROR state: disp_sel=3, result_bcd unchanged, busy=0.
  - In ERROR: enter press -> CONV_START (retry); back press -> IDLE with op=0.
- Undefined: no counter; CONV_WAIT waits indefinitely; ERROR is unreachable and disp_sel never equals 3.

Decomposition:
- Shared package calc_pkg holds:
  - the state encoding (IDLE, OP_SEL, CONV_START, CONV_WAIT, RESULT, ERROR);
  - the disp_sel codes (DISP_ZEROS, DISP_OP, DISP_RES, DISP_ERR);
  - the default NUM_OPS.
- Sub-module calc_btn_edge handles prev-register, press pulse and reset preload; it is instantiated four times.

Test Plan:
1. Hold enter_lvl=1 through reset, release rst -> no conv_start for 50 cycles; disp_sel=0.
2. From IDLE, up press -> OP_SEL, op=0. Then 3 up presses -> op=3. Then 4 down presses -> op=7 (wrap with NUM_OPS=8).
3. In OP_SEL with op=2, enter press -> conv_start high exactly 1 cycle and busy=1. Model drives conv_rdy 20 cycles later with conv_bcd=16'h0042 -> result_bcd=16'h0042, disp_sel=2, busy=0.
4. In OP_SEL with op=5, up and down pressed in the same cycle -> op stays 5. Then enter and back in the same cycle -> CONV_START.
5. rst=0 for one cycle during CONV_WAIT -> IDLE, result_bcd=0. A conv_rdy pulse 3 cycles later -> no change.
6. With CALC_TIMEOUT_EN and TIMEOUT_CYCLES=16, conv_rdy held low -> ERROR after 16 CONV_WAIT cycles, disp_sel=3. Then back press -> IDLE, op=0.
